// File: rtl/systolic_ws_drain_if.sv
// Bottom-psum capture and result-row drain bus of the weight-stationary array.
// Driven by the array/sequencer side (master) and consumed by systolic_ws_drain (slave).
interface systolic_ws_drain_if #(
    parameter int D_W   = 8,
    parameter int N     = 4,
    parameter int DEPTH = 8
);
    localparam int PW = 2 * D_W;
    localparam int CW = $clog2(DEPTH) + 1;

    logic                   clear;
    logic                   in_valid;
    logic                   in_ready;
    logic [N-1:0][PW-1:0]   m2;
    logic                   out_valid;
    logic                   out_ready;
    logic [N-1:0][PW-1:0]   out_data;
    logic [CW-1:0]          count;
    logic                   err_ovf;

    modport slave (
        input  clear, in_valid, m2, out_ready,
        output in_ready, out_valid, out_data, count, err_ovf
    );

    modport master (
        output clear, in_valid, m2, out_ready,
        input  in_ready, out_valid, out_data, count, err_ovf
    );
endinterface

// File: rtl/systolic_ws_drain.sv
// De-skews column-staggered psums into rows and buffers them; row visible N cycles after accept.
// Credit-based input (in_ready never over-commits the FIFO); output is valid/ready, head held on stall.
module systolic_ws_drain #(
    parameter int D_W   = 8,
    parameter int N     = 4,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    systolic_ws_drain_if.slave bus
);
    localparam int PW = 2 * D_W;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef logic [N-1:0][PW-1:0] row_t;

    // tok_q[i] is high i cycles after an accept; the accept itself plays the role of stage 0
    logic [N-1:1]   tok_q, tok_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           err_q, err_d;
    row_t           mem_q [DEPTH];

    logic [PW-1:0]  col_al [N];
    row_t           row_al;
    logic [31:0]    inflight;
    logic           in_ready;
    logic           accept;
    logic           push;
    logic           pop;

    always_comb begin
        inflight = '0;
        for (int i = 1; i < N; i++) begin
            inflight = inflight + 32'(tok_q[i]);
        end
    end

    // Credit counts rows stored plus rows still crossing the skew triangle; same-cycle pops are not credited
    assign in_ready = (32'(count_q) + inflight) < 32'(DEPTH);
    assign accept   = bus.in_valid & in_ready & ~bus.clear;
    assign push     = tok_q[N-1] & ~bus.clear;
    assign pop      = bus.out_ready & (count_q != '0) & ~bus.clear;

    for (genvar c = 0; c < N - 1; c++) begin : g_skew
        localparam int L = N - 1 - c;
        logic [PW-1:0] sr_q [L];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i < L; i++) sr_q[i] <= '0;
            end else if (bus.clear) begin
                for (int i = 0; i < L; i++) sr_q[i] <= '0;
            end else begin
                sr_q[0] <= bus.m2[c];
                for (int i = 1; i < L; i++) sr_q[i] <= sr_q[i-1];
            end
        end

        assign col_al[c] = sr_q[L-1];
    end

    assign col_al[N-1] = bus.m2[N-1];

    always_comb begin
        row_al = '0;
        for (int c = 0; c < N; c++) begin
            row_al[c] = col_al[c];
        end
    end

    always_comb begin
        tok_d    = '0;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
        err_d    = 1'b0;
        if (!bus.clear) begin
            tok_d[1] = accept;
            for (int i = 2; i < N; i++) begin
                tok_d[i] = tok_q[i-1];
            end
            wr_ptr_d = wr_ptr_q + AW'(push);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            count_d  = count_q + CW'(push) - CW'(pop);
            err_d    = err_q | (bus.in_valid & ~in_ready);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tok_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            tok_q    <= tok_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= row_al;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign bus.count     = count_q;
    assign bus.err_ovf   = err_q;

endmodule

// File: tb/tb_systolic_ws_drain.sv
// Directed table, corner-case sequences and random traffic checked against a row-queue model.
module tb_systolic_ws_drain;
    localparam int D_W   = 8;
    localparam int N     = 4;
    localparam int DEPTH = 8;
    localparam int PW    = 2 * D_W;

    typedef logic [N-1:0][PW-1:0] row_t;
    typedef struct { int t; row_t row; } pend_t;
    typedef struct {
        bit          v;
        bit          r;
        logic [15:0] base;
        bit          e_rdy;
        bit          e_ov;
        int          e_cnt;
        logic [15:0] e_d0;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    systolic_ws_drain_if #(.D_W(D_W), .N(N), .DEPTH(DEPTH)) bus();
    systolic_ws_drain #(.D_W(D_W), .N(N), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    row_t  mq[$];
    pend_t pq[$];
    bit    m_err  = 1'b0;

    function automatic bit m_ready();
        return (mq.size() + pq.size()) < DEPTH;
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int c = 0; c < N; c++) r[c] = PW'($urandom);
        return r;
    endfunction

    function automatic row_t base_row(input logic [15:0] base);
        row_t r;
        for (int c = 0; c < N; c++) r[c] = base + 16'(c);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_model();
        row_t head;
        head = '0;
        if (mq.size() > 0) head = mq[0];
        chk("in_ready",  64'(bus.in_ready),  64'(m_ready()));
        chk("out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
        chk("count",     64'(bus.count),     64'(mq.size()));
        chk("out_data",  64'(bus.out_data),  64'(head));
        chk("err_ovf",   64'(bus.err_ovf),   64'(m_err));
    endtask

    // One clock: drive at posedge+1, compare at negedge, advance model at posedge
    task automatic cycle(input bit v, input bit r, input bit clr, input row_t row);
        row_t  m;
        bit    rdy;
        pend_t e;
        rdy = m_ready();
        m = rand_row();
        m[0] = row[0];
        for (int c = 1; c < N; c++) begin
            foreach (pq[k]) if (pq[k].t == cyc - c) m[c] = pq[k].row[c];
        end
        bus.in_valid  = v;
        bus.out_ready = r;
        bus.clear     = clr;
        bus.m2        = m;
        @(negedge clk);
        check_model();
        @(posedge clk);
        if (clr) begin
            mq.delete();
            pq.delete();
            m_err = 1'b0;
        end else begin
            if (v && !rdy) m_err = 1'b1;
            if (r && mq.size() > 0) void'(mq.pop_front());
            if (pq.size() > 0 && pq[0].t + N - 1 == cyc) begin
                e = pq.pop_front();
                mq.push_back(e.row);
            end
            if (v && rdy) pq.push_back('{cyc, row});
        end
        cyc++;
        #1;
    endtask

    vec_t tbl[14];
    int   dut_acc;
    row_t fresh;

    initial begin
        tbl[0]  = '{1, 0, 16'h0100, 1, 0, 0, 16'h0000};
        tbl[1]  = '{0, 0, 16'h0000, 1, 0, 0, 16'h0000};
        tbl[2]  = '{0, 0, 16'h0000, 1, 0, 0, 16'h0000};
        tbl[3]  = '{0, 0, 16'h0000, 1, 0, 0, 16'h0000};
        tbl[4]  = '{0, 1, 16'h0000, 1, 1, 1, 16'h0100};
        tbl[5]  = '{0, 0, 16'h0000, 1, 0, 0, 16'h0000};
        tbl[6]  = '{1, 1, 16'h0000, 1, 0, 0, 16'h0000};
        tbl[7]  = '{1, 1, 16'h0010, 1, 0, 0, 16'h0000};
        tbl[8]  = '{1, 1, 16'h0020, 1, 0, 0, 16'h0000};
        tbl[9]  = '{0, 1, 16'h0000, 1, 0, 0, 16'h0000};
        tbl[10] = '{0, 1, 16'h0000, 1, 1, 1, 16'h0000};
        tbl[11] = '{0, 1, 16'h0000, 1, 1, 1, 16'h0010};
        tbl[12] = '{0, 1, 16'h0000, 1, 1, 1, 16'h0020};
        tbl[13] = '{0, 1, 16'h0000, 1, 0, 0, 16'h0000};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.clear     = 1'b0;
        bus.m2        = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data",  64'(bus.out_data),  64'd0);
        chk("rst_count",     64'(bus.count),     64'd0);
        chk("rst_err_ovf",   64'(bus.err_ovf),   64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single row, then three back-to-back rows with row k column c = k*16+c
        for (int i = 0; i < 14; i++) begin
            chk("tbl_in_ready",  64'(bus.in_ready),    64'(tbl[i].e_rdy));
            chk("tbl_out_valid", 64'(bus.out_valid),   64'(tbl[i].e_ov));
            chk("tbl_count",     64'(bus.count),       64'(tbl[i].e_cnt));
            chk("tbl_out_d0",    64'(bus.out_data[0]), 64'(tbl[i].e_d0));
            cycle(tbl[i].v, tbl[i].r, 1'b0, base_row(tbl[i].base));
        end

        // Credit exhaustion with the consumer stalled
        dut_acc = 0;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) begin
                chk("credit_ready_low", 64'(bus.in_ready), 64'd0);
                chk("credit_no_ovf",    64'(bus.err_ovf),  64'd0);
            end
            if (bus.in_ready) dut_acc++;
            cycle(1'b1, 1'b0, 1'b0, rand_row());
        end
        chk("credit_accepts", 64'(dut_acc), 64'd8);
        chk("credit_ovf_set", 64'(bus.err_ovf), 64'd1);
        repeat (4) cycle(1'b0, 1'b0, 1'b0, rand_row());
        chk("credit_full_count", 64'(bus.count), 64'd8);

        // Full FIFO drained with out_ready toggling while new rows keep arriving
        for (int i = 0; i < 24; i++) cycle(1'b1, i[0], 1'b0, rand_row());
        repeat (12) cycle(1'b0, 1'b1, 1'b0, rand_row());
        chk("drain_empty", 64'(bus.count), 64'd0);

        // Clear with two rows stored and two still in the skew triangle
        repeat (4) cycle(1'b1, 1'b0, 1'b0, rand_row());
        cycle(1'b0, 1'b0, 1'b0, rand_row());
        chk("pre_clear_count", 64'(bus.count), 64'd2);
        cycle(1'b0, 1'b0, 1'b1, rand_row());
        chk("clear_count",     64'(bus.count),     64'd0);
        chk("clear_out_valid", 64'(bus.out_valid), 64'd0);
        chk("clear_in_ready",  64'(bus.in_ready),  64'd1);
        chk("clear_err_ovf",   64'(bus.err_ovf),   64'd0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 1'b0, rand_row());
            chk("clear_no_stale", 64'(bus.out_valid), 64'd0);
        end

        // Asynchronous reset in the middle of a stream, away from the clock edge
        repeat (6) cycle(1'b1, 1'b1, 1'b0, rand_row());
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_out_data",  64'(bus.out_data),  64'd0);
        chk("arst_count",     64'(bus.count),     64'd0);
        chk("arst_err_ovf",   64'(bus.err_ovf),   64'd0);
        mq.delete();
        pq.delete();
        m_err = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        fresh = rand_row();
        for (int i = 0; i <= N; i++) begin
            chk("arst_fresh_valid", 64'(bus.out_valid), 64'(i == N));
            if (i == N) chk("arst_fresh_data", 64'(bus.out_data), 64'(fresh));
            else        cycle(i == 0, 1'b0, 1'b0, fresh);
        end
        cycle(1'b0, 1'b1, 1'b0, rand_row());

        // Random traffic with occasional clears
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 49) == 0, rand_row());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
